nx_egress_serialiser: RTL and testbench

//  Sits directly downstream of the last nx_aggregator in the chain.

---
 rtl/nx_egress_serialiser_pkg.sv | 25 ++
 rtl/nx_fifo.sv | 62 ++++++
 rtl/nx_egress_serialiser.sv | 136 +++++++++++++
 tb/tb_nx_egress_serialiser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_egress_serialiser_pkg.sv
// Shared types and constants for the egress serialiser: node message layout,
// default host beat width and the serialiser FSM state encoding.
package nx_egress_serialiser_pkg;

  typedef struct packed {
    logic [3:0]  flags;
    logic [7:0]  node_id;
    logic [15:0] seq;
    logic [31:0] payload;
  } node_message_t;

  localparam int unsigned MSG_W          = $bits(node_message_t);
  localparam int unsigned EGRESS_SLICE_W = 32;

  typedef enum logic [0:0] {
    EGRESS_IDLE = 1'b0,
    EGRESS_SEND = 1'b1
  } egress_state_t;

  // Number of host beats needed to carry one message.
  function automatic int unsigned egress_slices(input int unsigned slice_w);
    return (MSG_W + slice_w - 1) / slice_w;
  endfunction

endpackage

// File: rtl/nx_fifo.sv
// Synchronous FIFO with registered pointers and registered full/empty flags.
// Push while full and pop while empty are ignored.
module nx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
      full    <= (count_d == CNT_W'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nx_egress_serialiser.sv
// Buffers aggregator messages and serialises each into SLICE_W-bit host beats,
// LSB slice first, with a last marker on the final slice.
module nx_egress_serialiser
  import nx_egress_serialiser_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SLICE_W = EGRESS_SLICE_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [MSG_W-1:0]   i_inbound_data,
  input  logic               i_inbound_valid,
  output logic               o_inbound_ready,
  output logic [SLICE_W-1:0] o_host_data,
  output logic               o_host_last,
  output logic               o_host_valid,
  input  logic               i_host_ready,
  output logic               o_idle,
  output logic [31:0]        o_msg_count
);

  localparam int unsigned SLICES  = egress_slices(SLICE_W);
  localparam int unsigned SHIFT_W = SLICES * SLICE_W;
  localparam int unsigned IDX_W   = $clog2(SLICES) + 1;

  egress_state_t      state_q;
  egress_state_t      state_d;
  logic [SHIFT_W-1:0] shreg_q;
  logic [SHIFT_W-1:0] shreg_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_q;
  logic               valid_d;
  logic               last_q;
  logic               last_d;
  logic [31:0]        count_q;
  logic [31:0]        count_d;
  logic               accept_en_q;
  logic               load;

  logic               fifo_push;
  logic [MSG_W-1:0]   fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;

  // Ready is held low during reset and only ever depends on registered occupancy.
  assign o_inbound_ready = accept_en_q && !fifo_full;
  assign fifo_push       = i_inbound_valid && o_inbound_ready;

  nx_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (fifo_push),
    .wdata (i_inbound_data),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    count_d = count_q;
    load    = 1'b0;

    unique case (state_q)
      EGRESS_IDLE: begin
        load = !fifo_empty;
      end
      EGRESS_SEND: begin
        if (i_host_ready) begin
          if (last_q) begin
            count_d = count_q + 32'd1;
            load    = !fifo_empty;
            if (fifo_empty) begin
              state_d = EGRESS_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              shreg_d = '0;
            end
          end else begin
            shreg_d = shreg_q >> SLICE_W;
            idx_d   = idx_q + IDX_W'(1);
            last_d  = (idx_d == IDX_W'(SLICES - 1));
          end
        end
      end
      default: begin
        state_d = EGRESS_IDLE;
      end
    endcase

    // Head of FIFO moves into the shift register; overrides the idle path above.
    if (load) begin
      state_d = EGRESS_SEND;
      shreg_d = SHIFT_W'(fifo_rdata);
      idx_d   = '0;
      valid_d = 1'b1;
      last_d  = (SLICES == 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= EGRESS_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      count_q     <= '0;
      accept_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      count_q     <= count_d;
      accept_en_q <= 1'b1;
    end
  end

  assign o_host_data  = shreg_q[SLICE_W-1:0];
  assign o_host_last  = last_q;
  assign o_host_valid = valid_q;
  assign o_msg_count  = count_q;
  assign o_idle       = fifo_empty && (state_q == EGRESS_IDLE) && !i_inbound_valid;

endmodule

// File: tb/tb_nx_egress_serialiser.sv
// Self-checking bench for nx_egress_serialiser at SLICE_W=8: table-driven single
// messages, stall/full corner sequences, random backpressure and mid-message reset.
module tb_nx_egress_serialiser;
  import nx_egress_serialiser_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SLICE_W = 8;
  localparam int unsigned SLICES  = (MSG_W + SLICE_W - 1) / SLICE_W;

  logic               clk        = 1'b0;
  logic               rst_n      = 1'b1;
  logic [MSG_W-1:0]   in_data    = '0;
  logic               in_valid   = 1'b0;
  logic               in_ready;
  logic [SLICE_W-1:0] host_data;
  logic               host_last;
  logic               host_valid;
  logic               host_ready = 1'b0;
  logic               idle;
  logic [31:0]        msg_count;

  int tests   = 0;
  int fails   = 0;
  int rx_msgs = 0;
  logic [MSG_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  nx_egress_serialiser #(
    .DEPTH   (DEPTH),
    .SLICE_W (SLICE_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_inbound_data  (in_data),
    .i_inbound_valid (in_valid),
    .o_inbound_ready (in_ready),
    .o_host_data     (host_data),
    .o_host_last     (host_last),
    .o_host_valid    (host_valid),
    .i_host_ready    (host_ready),
    .o_idle          (idle),
    .o_msg_count     (msg_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference slicing: beat k of a message is bits [8k+7:8k], zero above MSG_W.
  function automatic logic [7:0] beat_of(input logic [MSG_W-1:0] m, input int k);
    logic [63:0] w;
    w = 64'(m);
    return w[8*k +: 8];
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[MSG_W-1:0];
  endfunction

  // Monitor: records accepted inbound messages, reassembles host beats, checks stability.
  logic [63:0]        acc = '0;
  int                 nbeat = 0;
  logic               pv = 1'b0;
  logic               pr = 1'b0;
  logic               pl = 1'b0;
  logic [SLICE_W-1:0] pd = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc = '0; nbeat = 0; pv = 1'b0; rx_msgs = 0;
      exp_q.delete();
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(host_valid), 64'd1);
        chk("hold_data", 64'(host_data), 64'(pd));
        chk("hold_last", 64'(host_last), 64'(pl));
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (host_valid && host_ready) begin
        acc = acc | (64'(host_data) << (8 * nbeat));
        nbeat++;
        if (host_last) begin
          chk("msg_beats", 64'(nbeat), 64'(SLICES));
          chk("msg_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) chk("msg_data", acc, 64'(exp_q.pop_front()));
          rx_msgs++;
          acc = '0; nbeat = 0;
        end
      end
      pv = host_valid; pr = host_ready; pd = host_data; pl = host_last;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0; host_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Returns at #1 after the accepting edge.
  task automatic push_msg(input logic [MSG_W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_data = d; in_valid = 1'b1;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input int n);
    for (int c = 0; c < 3000 && !(rx_msgs == n && idle); c++) @(negedge clk);
  endtask

  typedef struct {
    logic [MSG_W-1:0] data;
    logic [7:0]       beat0;
    logic [7:0]       top;
  } vec_t;

  vec_t             tbl[5];
  logic [MSG_W-1:0] msgs[6];
  logic [MSG_W-1:0] m5;
  int               k;
  bit               cap;
  bit               a_done;

  initial begin
    tbl[0] = '{data: 60'hFFF_FFFF_FFFF_FFFF, beat0: 8'hFF, top: 8'h0F};
    tbl[1] = '{data: 60'h000_0000_0000_0000, beat0: 8'h00, top: 8'h00};
    tbl[2] = '{data: 60'h123_4567_89AB_CDEF, beat0: 8'hEF, top: 8'h01};
    tbl[3] = '{data: 60'h800_0000_0000_0001, beat0: 8'h01, top: 8'h08};
    tbl[4] = '{data: 60'hA5A_5A5A_5A5A_5A5A, beat0: 8'h5A, top: 8'h0A};

    // 1. Reset values, checked while reset is asserted and after release.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(host_valid), 64'd0);
    chk("rst_last", 64'(host_last), 64'd0);
    chk("rst_data", 64'(host_data), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_count", 64'(msg_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_idle", 64'(idle), 64'd1);
    chk("post_rst_valid", 64'(host_valid), 64'd0);

    // 2. Table of single messages, host always ready: latency, beats, last, count.
    host_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_msg(tbl[i].data);
      chk("lat_not_yet", 64'(host_valid), 64'd0);
      @(posedge clk); #1;
      for (int b = 0; b < int'(SLICES); b++) begin
        chk("beat_valid", 64'(host_valid), 64'd1);
        chk("beat_data", 64'(host_data), 64'(beat_of(tbl[i].data, b)));
        chk("beat_last", 64'(host_last), 64'(b == int'(SLICES) - 1));
        if (b == 0) chk("tbl_beat0", 64'(host_data), 64'(tbl[i].beat0));
        if (b == int'(SLICES) - 1) chk("tbl_top", 64'(host_data), 64'(tbl[i].top));
        @(posedge clk); #1;
      end
      chk("tbl_done_valid", 64'(host_valid), 64'd0);
      chk("tbl_count", 64'(msg_count), 64'(i + 1));
      chk("tbl_idle", 64'(idle), 64'd1);
    end

    // 3. Host stalled: DEPTH in FIFO plus one in the shift register, then ready drops.
    do_reset();
    for (int i = 0; i < 6; i++) msgs[i] = rand_msg();
    k = 0;
    in_data = msgs[0]; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_ready", 64'(in_ready), 64'(k < int'(DEPTH) + 1));
      cap = in_ready;
      @(posedge clk); #1;
      if (cap && k < 5) begin
        k++;
        in_data = msgs[k];
      end
    end
    chk("stall_accepted", 64'(k), 64'(DEPTH + 1));
    chk("stall_valid", 64'(host_valid), 64'd1);
    chk("stall_beat0", 64'(host_data), 64'(beat_of(msgs[0], 0)));
    chk("stall_count", 64'(msg_count), 64'd0);

    // 6. FIFO full; pop on the last beat edge must not let the held push through.
    host_ready = 1'b1;
    for (int c = 0; c < int'(SLICES); c++) begin
      @(negedge clk);
      chk("full_refuse", 64'(in_ready), 64'd0);
      if (c == int'(SLICES) - 1) chk("full_pop_last", 64'(host_last && host_valid), 64'd1);
    end
    @(negedge clk);
    chk("full_accept_next", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(6);
    chk("full_rx", 64'(rx_msgs), 64'd6);
    chk("full_count", 64'(msg_count), 64'd6);
    chk("full_leftover", 64'(exp_q.size()), 64'd0);

    // 4. Random inbound gaps and random host backpressure over 100 messages.
    do_reset();
    a_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(posedge clk); #1;
          end
          push_msg(rand_msg());
        end
        a_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !(a_done && rx_msgs == 100); c++) begin
          host_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        host_ready = 1'b1;
      end
    join
    wait_drain(100);
    chk("rand_rx", 64'(rx_msgs), 64'd100);
    chk("rand_count", 64'(msg_count), 64'd100);
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    // 5. Asynchronous reset while beat 2 is on the link.
    m5 = rand_msg();
    push_msg(m5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_beat2", 64'(host_data), 64'(beat_of(m5, 2)));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(host_valid), 64'd0);
    chk("mid_rst_last", 64'(host_last), 64'd0);
    chk("mid_rst_data", 64'(host_data), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("mid_rst_count", 64'(msg_count), 64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_after_idle", 64'(idle), 64'd1);
    chk("mid_after_valid", 64'(host_valid), 64'd0);
    chk("mid_after_count", 64'(msg_count), 64'd0);
    chk("mid_after_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
